// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit: FSM state encodings,
// next-PC selector, reset PC and fault cause codes.
package inst_fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_HOLD     = 2'd0,
    NPC_SEQ      = 2'd1,
    NPC_REDIRECT = 2'd2
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUSERR   = 2'b10;

  localparam logic RST_ACTIVE_N = 1'b0;

  localparam int INST_BYTES = 4;

  // RV32I without the C extension needs every fetch target word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the fetch unit's imem request/response, decode handshake,
// redirect and fault signals; master is the fetch unit, slave its environment.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);

  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [ADDR_W-1:0] imem_req_addr_o;
  logic              imem_rsp_valid_i;
  logic [INST_W-1:0] imem_rsp_data_i;
  logic              imem_rsp_err_i;

  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;

  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;

  logic              fault_o;
  logic [1:0]        fault_cause_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    output inst_valid_o, pc_o, inst_o,
    input  inst_ready_i,
    input  redirect_i, redirect_pc_i,
    output fault_o, fault_cause_o
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    input  inst_valid_o, pc_o, inst_o,
    output inst_ready_i,
    output redirect_i, redirect_pc_i,
    input  fault_o, fault_cause_o
  );

endinterface

// File: rtl/inst_fetch_unit_next_pc.sv
// Combinational next-PC select (hold, sequential +4, redirect target) plus the
// misalignment flag for the redirect target.
module fetch_next_pc
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  npc_sel_e          i_sel,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_misaligned
);

  // Sequential increment wraps naturally at 2^ADDR_W.
  always_comb begin
    o_next_pc = i_pc;
    unique case (i_sel)
      NPC_HOLD:     o_next_pc = i_pc;
      NPC_SEQ:      o_next_pc = i_pc + ADDR_W'(INST_BYTES);
      NPC_REDIRECT: o_next_pc = i_redirect_pc;
      default:      o_next_pc = i_pc;
    endcase
  end

  assign o_misaligned = is_misaligned(i_redirect_pc[1:0]);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch initiator: owns the architectural PC, keeps exactly one imem
// request outstanding, presents {pc, inst} to decode and handles redirects/faults.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.master bus
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_kill;
  logic [1:0]        r_cause;

  fetch_state_e      w_state_nxt;
  logic              w_kill_nxt;
  logic [1:0]        w_cause_nxt;
  logic              w_inst_load;
  npc_sel_e          w_npc_sel;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_misaligned;
  logic              w_redirect_ok;
  logic              w_redirect_bad;

  fetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .i_pc          (r_pc),
    .i_redirect_pc (bus.redirect_pc_i),
    .i_sel         (w_npc_sel),
    .o_next_pc     (w_next_pc),
    .o_misaligned  (w_misaligned)
  );

  assign w_redirect_ok  = bus.redirect_i && !w_misaligned;
  assign w_redirect_bad = bus.redirect_i &&  w_misaligned;

  // Misaligned targets fault from any live state; otherwise a redirect only
  // retargets the PC and, if a request is already in flight, marks it for discard.
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    w_cause_nxt = r_cause;
    w_npc_sel   = NPC_HOLD;
    w_inst_load = 1'b0;

    if (w_redirect_bad && (r_state != ST_FAULT)) begin
      w_state_nxt = ST_FAULT;
      w_cause_nxt = FAULT_MISALIGN;
      w_npc_sel   = NPC_REDIRECT;
      w_kill_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (w_redirect_ok) begin
            w_npc_sel = NPC_REDIRECT;
          end
          if (bus.imem_req_ready_i) begin
            w_state_nxt = ST_WAIT;
            w_kill_nxt  = w_redirect_ok;
          end
        end
        ST_WAIT: begin
          if (w_redirect_ok) begin
            w_npc_sel = NPC_REDIRECT;
            if (bus.imem_rsp_valid_i) begin
              w_state_nxt = ST_REQ;
              w_kill_nxt  = 1'b0;
            end else begin
              w_kill_nxt = 1'b1;
            end
          end else if (bus.imem_rsp_valid_i) begin
            // A killed response is dropped before its error bit is even looked at.
            if (r_kill) begin
              w_state_nxt = ST_REQ;
              w_kill_nxt  = 1'b0;
            end else if (bus.imem_rsp_err_i) begin
              w_state_nxt = ST_FAULT;
              w_cause_nxt = FAULT_BUSERR;
            end else begin
              w_state_nxt = ST_VALID;
              w_inst_load = 1'b1;
            end
          end
        end
        ST_VALID: begin
          if (w_redirect_ok) begin
            w_npc_sel   = NPC_REDIRECT;
            w_state_nxt = ST_REQ;
          end else if (bus.inst_ready_i) begin
            w_npc_sel   = NPC_SEQ;
            w_state_nxt = ST_REQ;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_kill  <= 1'b0;
      r_cause <= FAULT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_next_pc;
      r_kill  <= w_kill_nxt;
      r_cause <= w_cause_nxt;
      if (w_inst_load) begin
        r_inst <= bus.imem_rsp_data_i;
      end
    end
  end

  assign bus.imem_req_valid_o = (r_state == ST_REQ);
  assign bus.imem_req_addr_o  = (r_state == ST_REQ) ? r_pc : '0;
  assign bus.inst_valid_o     = (r_state == ST_VALID);
  assign bus.pc_o             = r_pc;
  assign bus.inst_o           = r_inst;
  assign bus.fault_o          = (r_state == ST_FAULT);
  assign bus.fault_cause_o    = r_cause;

  // IDLE is exempt: a memory may still be finishing a transaction cut off by reset.
  a_rsp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst == RST_ACTIVE_N)
      (bus.imem_rsp_valid_i && (r_state != ST_IDLE)) |-> (r_state == ST_WAIT)
  ) else $error("imem response arrived outside WAIT");

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a table of sequential fetches plus
// hand-written redirect, fault and reset sequences against a small imem model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  inst_fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          holdCycles;
  } fetchVec_t;

  fetchVec_t   vecs [3];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          rspLatency = 1;
  int          pendLeft = 0;
  logic [31:0] pendAddr = '0;
  logic        errEnable = 1'b0;
  logic [31:0] errAddr = '0;
  logic        acceptedNow = 1'b0;
  logic [31:0] acceptedAddr = '0;
  int          acceptCyc = 0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h8000_0000: return 32'h0000_0013;
      32'h8000_0004: return 32'h0010_0093;
      default:       return {addr[15:0], 16'h0113};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
  endtask

  // One clock: note whether the request was accepted, then play the imem model.
  task automatic stepCycle();
    logic        acc;
    logic [31:0] addr;
    acc  = bus.imem_req_valid_o && bus.imem_req_ready_i;
    addr = bus.imem_req_addr_o;
    @(posedge clk);
    #1;
    cyc++;
    acceptedNow = acc;
    if (acc) begin
      acceptedAddr = addr;
      acceptCyc    = cyc - 1;
      pendAddr     = addr;
      pendLeft     = rspLatency;
    end
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_err_i   = 1'b0;
    if (pendLeft > 0) begin
      pendLeft--;
      if (pendLeft == 0) begin
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = memWord(pendAddr);
        bus.imem_rsp_err_i   = errEnable && (pendAddr == errAddr);
      end
    end
  endtask

  task automatic waitAccept(input string name, input logic [31:0] expAddr);
    int n;
    n = 0;
    acceptedNow = 1'b0;
    while (!acceptedNow && n < 20) begin
      stepCycle();
      n++;
    end
    checkBit({name, " accepted"}, acceptedNow, 1'b1);
    checkOutput({name, " req addr"}, acceptedAddr, expAddr);
  endtask

  task automatic waitValid(input string name, input logic [31:0] expPc, input logic [31:0] expInst);
    int n;
    n = 0;
    while (!bus.inst_valid_o && n < 20) begin
      stepCycle();
      n++;
    end
    checkBit({name, " valid"}, bus.inst_valid_o, 1'b1);
    checkOutput({name, " pc"}, bus.pc_o, expPc);
    checkOutput({name, " inst"}, bus.inst_o, expInst);
  endtask

  task automatic consume();
    bus.inst_ready_i = 1'b1;
    stepCycle();
    bus.inst_ready_i = 1'b0;
  endtask

  task automatic applyReset();
    rst                  = 1'b0;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.inst_ready_i     = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_err_i   = 1'b0;
    pendLeft             = 0;
    rspLatency           = 1;
    errEnable            = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b1;
  endtask

  task automatic checkResetOutputs(input string name);
    checkBit({name, " req_valid"}, bus.imem_req_valid_o, 1'b0);
    checkOutput({name, " req_addr"}, bus.imem_req_addr_o, 32'h0);
    checkBit({name, " inst_valid"}, bus.inst_valid_o, 1'b0);
    checkOutput({name, " inst"}, bus.inst_o, 32'h0);
    checkBit({name, " fault"}, bus.fault_o, 1'b0);
    checkOutput({name, " cause"}, 32'(bus.fault_cause_o), 32'h0);
    checkOutput({name, " pc"}, bus.pc_o, RESET_PC);
  endtask

  // One table row: fetch, check presentation latency, hold off decode, consume.
  task automatic applyStimulus(input fetchVec_t v, input int idx);
    string tag;
    tag = $sformatf("seq%0d", idx);
    waitAccept(tag, v.pc);
    waitValid(tag, v.pc, v.inst);
    checkOutput({tag, " latency"}, 32'(cyc - acceptCyc), 32'd2);
    for (int i = 0; i < v.holdCycles; i++) begin
      stepCycle();
      checkBit({tag, " hold valid"}, bus.inst_valid_o, 1'b1);
      checkOutput({tag, " hold pc"}, bus.pc_o, v.pc);
      checkOutput({tag, " hold inst"}, bus.inst_o, v.inst);
      checkBit({tag, " hold no req"}, bus.imem_req_valid_o, 1'b0);
    end
    consume();
  endtask

  initial begin
    vecs[0] = '{pc: 32'h8000_0000, inst: 32'h0000_0013, holdCycles: 0};
    vecs[1] = '{pc: 32'h8000_0004, inst: 32'h0010_0093, holdCycles: 5};
    vecs[2] = '{pc: 32'h8000_0008, inst: 32'h0008_0113, holdCycles: 2};

    rst = 1'b1;
    bus.imem_rsp_data_i = '0;
    #2;
    applyReset();
    checkResetOutputs("reset");

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Redirect while waiting; the killed response also carries a bus error.
    rspLatency = 2;
    errEnable  = 1'b1;
    errAddr    = 32'h8000_000C;
    waitAccept("wait redir", 32'h8000_000C);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0100;
    stepCycle();
    bus.redirect_i = 1'b0;
    checkOutput("wait redir pc", bus.pc_o, 32'h8000_0100);
    checkBit("wait redir no valid", bus.inst_valid_o, 1'b0);
    stepCycle();
    checkBit("killed err no fault", bus.fault_o, 1'b0);
    checkBit("killed not presented", bus.inst_valid_o, 1'b0);
    checkBit("kill req valid", bus.imem_req_valid_o, 1'b1);
    checkOutput("kill req addr", bus.imem_req_addr_o, 32'h8000_0100);
    rspLatency = 1;
    errEnable  = 1'b0;
    waitAccept("after kill", 32'h8000_0100);
    waitValid("after kill", 32'h8000_0100, 32'h0100_0113);

    // Redirect together with the decode handshake.
    bus.inst_ready_i  = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0200;
    stepCycle();
    bus.inst_ready_i = 1'b0;
    bus.redirect_i   = 1'b0;
    checkBit("valid redir drop", bus.inst_valid_o, 1'b0);
    checkOutput("valid redir addr", bus.imem_req_addr_o, 32'h8000_0200);
    waitAccept("valid redir", 32'h8000_0200);
    waitValid("valid redir", 32'h8000_0200, 32'h0200_0113);
    consume();

    // Redirect in REQ, first with the request stalled, then coincident with acceptance.
    bus.imem_req_ready_i = 1'b0;
    bus.redirect_i       = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0300;
    stepCycle();
    checkOutput("req stall redir addr", bus.imem_req_addr_o, 32'h8000_0300);
    bus.imem_req_ready_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0400;
    stepCycle();
    bus.redirect_i = 1'b0;
    checkOutput("req accept redir pc", bus.pc_o, 32'h8000_0400);
    waitAccept("req accept redir", 32'h8000_0400);
    waitValid("req accept redir", 32'h8000_0400, 32'h0400_0113);

    // Misaligned target while an instruction is presented.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0102;
    stepCycle();
    bus.redirect_i = 1'b0;
    checkBit("misalign fault", bus.fault_o, 1'b1);
    checkOutput("misalign cause", 32'(bus.fault_cause_o), 32'h1);
    checkOutput("misalign pc", bus.pc_o, 32'h8000_0102);
    checkBit("misalign no valid", bus.inst_valid_o, 1'b0);
    bus.inst_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.redirect_i    = (i == 0);
      bus.redirect_pc_i = 32'h8000_0500;
      stepCycle();
      checkBit("fault no req", bus.imem_req_valid_o, 1'b0);
      checkBit("fault sticky", bus.fault_o, 1'b1);
      checkOutput("fault pc held", bus.pc_o, 32'h8000_0102);
    end
    bus.redirect_i   = 1'b0;
    bus.inst_ready_i = 1'b0;

    // Live bus error on the second fetch after reset.
    applyReset();
    errEnable = 1'b1;
    errAddr   = 32'h8000_0004;
    waitAccept("buserr first", 32'h8000_0000);
    waitValid("buserr first", 32'h8000_0000, 32'h0000_0013);
    consume();
    waitAccept("buserr", 32'h8000_0004);
    stepCycle();
    checkBit("buserr fault", bus.fault_o, 1'b1);
    checkOutput("buserr cause", 32'(bus.fault_cause_o), 32'h2);
    checkOutput("buserr pc", bus.pc_o, 32'h8000_0004);
    checkBit("buserr no valid", bus.inst_valid_o, 1'b0);
    checkBit("buserr no req", bus.imem_req_valid_o, 1'b0);

    // Reset asserted while a request is outstanding, then a stray response.
    applyReset();
    waitAccept("midrst first", 32'h8000_0000);
    waitValid("midrst first", 32'h8000_0000, 32'h0000_0013);
    consume();
    rspLatency = 2;
    waitAccept("midrst wait", 32'h8000_0004);
    rst = 1'b0;
    #1;
    checkResetOutputs("midrst");
    pendLeft = 0;
    stepCycle();
    stepCycle();
    rst = 1'b1;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'hDEAD_BEEF;
    bus.imem_rsp_err_i   = 1'b1;
    stepCycle();
    checkBit("stray no fault", bus.fault_o, 1'b0);
    checkBit("stray no valid", bus.inst_valid_o, 1'b0);
    checkBit("stray req valid", bus.imem_req_valid_o, 1'b1);
    checkOutput("stray req addr", bus.imem_req_addr_o, 32'h8000_0000);
    rspLatency = 1;
    waitAccept("post stray", 32'h8000_0000);
    waitValid("post stray", 32'h8000_0000, 32'h0000_0013);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch initiator for the NPC RV32I core.
- Holds the architectural PC and issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface.
- Presents {pc, inst} to the decode stage with a valid/ready handshake.
- Accepts PC redirects from the control transfer unit, discards any stale in-flight response, and flags misaligned-target and bus faults.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request this cycle.
- imem_req_addr_o  out  ADDR_W  fetch address.
- imem_rsp_valid_i  in  1  response valid (always accepted).
- imem_rsp_data_i  in  INST_W  fetched instruction.
- imem_rsp_err_i  in  1  bus error, qualified by imem_rsp_valid_i.
- inst_valid_o  out  1  {pc_o, inst_o} valid to decode.
- inst_ready_i  in  1  decode consumes this cycle.
- pc_o  out  ADDR_W  PC of presented instruction; faulting PC while in FAULT.
- inst_o  out  INST_W  presented instruction.
- redirect_i  in  1  control transfer taken.
- redirect_pc_i  in  ADDR_W  redirect target.
- fault_o  out  1  sticky fault flag.
- fault_cause_o  out  2  01 = misaligned target, 10 = bus error, 00 = none.

Behaviour:

Reset (rst = 0, async):
- state = IDLE, pc = RESET_PC, kill = 0.
- All outputs 0, except pc_o = RESET_PC.

States and transitions:
- IDLE: one cycle after reset release, go to REQ.
- REQ: imem_req_valid_o = 1, imem_req_addr_o = pc. When imem_req_ready_i = 1, go to WAIT.
- WAIT: wait for imem_rsp_valid_i.
  - kill = 1: drop the response, clear kill, go to REQ.
  - err = 1: go to FAULT with cause 10.
  - Otherwise: register inst, go to VALID.
- VALID: inst_valid_o = 1; pc_o and inst_o stay stable until handshake. When inst_ready_i = 1, pc <= pc + 4 (mod 2^32) and go to REQ.
- FAULT: terminal until reset. No requests issued, inst_valid_o = 0, fault_o = 1.

Latency:
- Request accepted in cycle N; response earliest in N+1; inst_valid_o earliest in N+2.
- Back-to-back throughput is one instruction per 3 cycles minimum. No prefetch, exactly one request outstanding.

Redirect handling (priority: reset > fault > redirect > normal sequencing):
- Target misaligned (redirect_pc_i[1:0] != 0), any state: go to FAULT, cause 01, pc_o = redirect_pc_i.
- In REQ with imem_req_ready_i = 0: pc <= redirect_pc_i; the next request carries the new address. The imem protocol permits the address to change while unaccepted.
- In REQ with imem_req_ready_i = 1 in the same cycle: the old request is accepted, kill is set, pc <= target, go to WAIT.
- In WAIT without a response: kill is set, pc <= target.
- In WAIT with a response in the same cycle: the response is dropped, even if err; go to REQ.
- In VALID: inst_valid_o drops next cycle, pc <= target, go to REQ. If inst_ready_i = 1 in the same cycle, that instruction still counts as consumed, but the next PC is the target, not pc + 4.
- redirect_i in IDLE or FAULT: ignored, except a misaligned target in IDLE, which still faults.

Other rules:
- A bus error on a killed response never faults.
- A response arriving outside WAIT is a protocol violation; it is ignored and assertion-flagged in simulation.
- Reset asserted mid-transaction: immediate return to the IDLE reset values. A late response after reset release is ignored, since the state is not WAIT.

Decomposition:
- defines.v gains:
  - `FETCH_STATE_BUS and the 3-bit encodings for IDLE, REQ, WAIT, VALID, FAULT.
  - `RESET_PC.
  - `FAULT_NONE, `FAULT_MISALIGN, `FAULT_BUSERR.
  - `RST_ACTIVE_N for the active-low level.
- One combinational sub-module, fetch_next_pc, selects the next PC from {hold, pc+4, redirect_pc} and computes the misalign flag. The FSM and registers stay in inst_fetch_unit.

Test Plan:
1. Sequential fetch:
   - Stimulus: reset release; imem with ready = 1 and a 1-cycle response returning 32'h0000_0013 at 0x8000_0000 and 32'h0010_0093 at 0x8000_0004; inst_ready_i = 1.
   - Required: pc_o/inst_o show 0x8000_0000/0x13, then 0x8000_0004/0x00100093; each inst_valid_o 2 cycles after acceptance.
2. Decode backpressure:
   - Stimulus: inst_ready_i = 0 for 5 cycles while VALID.
   - Required: pc_o and inst_o stable and inst_valid_o = 1 throughout; no new request.
3. Redirect during WAIT:
   - Stimulus: redirect_i to 0x8000_0100 one cycle before the response for 0x8000_0004.
   - Required: that response is dropped and never presented; next request address is 0x8000_0100.
4. Redirect coincident with handshake in VALID:
   - Stimulus: redirect_i to 0x8000_0200 in the same cycle as inst_ready_i.
   - Required: next request is 0x8000_0200, not pc + 4.
5. Misaligned redirect:
   - Stimulus: redirect_pc_i = 0x8000_0102.
   - Required: fault_o = 1, fault_cause_o = 01, pc_o = 0x8000_0102; imem_req_valid_o stays 0 until reset.
6. Bus error and mid-transaction reset:
   - Stimulus: return imem_rsp_err_i = 1 on a live response.
   - Required: FAULT with cause 10.
   - Stimulus: assert rst in WAIT.
   - Required: outputs zero immediately and pc_o = 0x8000_0000; a stray response after release is ignored.
